fifo_word_packer: RTL and testbench



---
 rtl/fifo_word_packer_pkg.sv | 19 +
 rtl/fifo_word_packer_if.sv | 26 ++
 rtl/fifo_word_packer_idle_timer.sv | 47 ++++
 rtl/fifo_word_packer.sv | 98 +++++++++
 tb/tb_fifo_word_packer.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_word_packer_pkg.sv
// Shared types and constants for the FIFO word packer.
package fifo_word_packer_pkg;

    // Packer FSM: FILL gathers lanes, HOLD presents the word until accepted.
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Lane count of the reference build and its lane-index width.
    localparam int unsigned cDefaultLanes = 4;
    localparam int unsigned cLaneIdxW     = $clog2(cDefaultLanes);

    // Lane-index width for an arbitrary lane count (pLANES >= 2).
    function automatic int unsigned laneIdxW(input int unsigned lanes);
        return $clog2(lanes);
    endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// FIFO read side and word-stream side of the packer, bundled as one interface.
interface fifo_word_packer_if #(
    parameter int unsigned pBITS  = 8,
    parameter int unsigned pLANES = 4
);
    logic                    ififo_empty;
    logic [pBITS-1:0]        ififo_data;
    logic                    ofifo_rd;
    logic                    iflush;
    logic [pBITS*pLANES-1:0] owd_data;
    logic [pLANES-1:0]       owd_keep;
    logic                    owd_valid;
    logic                    iwd_ready;

    // Packer side.
    modport master (
        input  ififo_empty, ififo_data, iflush, iwd_ready,
        output ofifo_rd, owd_data, owd_keep, owd_valid
    );

    // Environment side: upstream FIFO, flush source and downstream sink.
    modport slave (
        output ififo_empty, ififo_data, iflush, iwd_ready,
        input  ofifo_rd, owd_data, owd_keep, owd_valid
    );
endinterface

// File: rtl/fifo_word_packer_idle_timer.sv
// Saturating idle counter; expired fires in the cycle the count would reach pTIMEOUT.
module idle_timer #(
    parameter int unsigned pTIMEOUT = 16
) (
    input  logic iclk,
    input  logic ireset,
    input  logic ienable,
    input  logic iclear,
    output logic oexpired
);

    if (pTIMEOUT == 0) begin : gDisabled
        logic unusedInputs;
        assign unusedInputs = ^{iclk, ireset, ienable, iclear};
        assign oexpired     = 1'b0;
    end else begin : gTimer
        localparam int unsigned   cW    = $clog2(pTIMEOUT + 1);
        localparam logic [cW-1:0] cMax  = cW'(pTIMEOUT);
        localparam logic [cW-1:0] cLast = cW'(pTIMEOUT - 1);

        logic [cW-1:0] countQ, countD;

        // Next count: clear has priority, otherwise count up to saturation.
        always_comb begin
            countD = countQ;
            if (iclear) begin
                countD = '0;
            end else if (ienable && (countQ != cMax)) begin
                countD = countQ + 1'b1;
            end
        end

        // Count register.
        always_ff @(posedge iclk or posedge ireset) begin
            if (ireset) begin
                countQ <= '0;
            end else begin
                countQ <= countD;
            end
        end

        // Expiry is judged on the increment about to happen, so the flush
        // lands on the same edge the count reaches pTIMEOUT.
        assign oexpired = ienable && (countQ >= cLast);
    end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops bytes from the upstream FIFO and packs them into pLANES-wide words.
module fifo_word_packer
    import fifo_word_packer_pkg::*;
#(
    parameter int unsigned pBITS    = 8,
    parameter int unsigned pLANES   = 4,
    parameter int unsigned pTIMEOUT = 16
) (
    input logic                 iclk,
    input logic                 ireset,
    fifo_word_packer_if.master  bus
);

    localparam int unsigned        cIdxW     = laneIdxW(pLANES);
    localparam int unsigned        cCntW     = cIdxW + 1;
    localparam logic [cCntW-1:0]   cLastLane = cCntW'(pLANES - 1);

    state_t                        stateQ, stateD;
    logic [pLANES-1:0][pBITS-1:0]  laneQ, laneD;
    logic [pLANES-1:0]             keepQ, keepD;
    logic [cCntW-1:0]              cntQ, cntD;
    logic [cIdxW-1:0]              wrIdx;
    logic                          pop;
    logic                          timerEn;
    logic                          timerClr;
    logic                          expired;

    // Pop whenever filling and data is present; reset gates it combinationally.
    assign pop   = (stateQ == FILL) && !bus.ififo_empty && !ireset;
    assign wrIdx = cntQ[cIdxW-1:0];

    // Idle time only accrues on a partial word that is not being fed.
    assign timerEn  = (stateQ == FILL) && (cntQ != '0) && !pop;
    assign timerClr = pop || ((stateQ == FILL) && (stateD == HOLD));

    idle_timer #(
        .pTIMEOUT (pTIMEOUT)
    ) uIdleTimer (
        .iclk     (iclk),
        .ireset   (ireset),
        .ienable  (timerEn),
        .iclear   (timerClr),
        .oexpired (expired)
    );

    // Next-state, lane write and word release.
    always_comb begin
        stateD = stateQ;
        laneD  = laneQ;
        keepD  = keepQ;
        cntD   = cntQ;
        case (stateQ)
            FILL: begin
                if (pop) begin
                    laneD[wrIdx] = bus.ififo_data;
                    keepD[wrIdx] = 1'b1;
                    cntD         = cntQ + 1'b1;
                end
                // A flush with nothing held and nothing arriving is dropped.
                if ((pop && (cntQ == cLastLane)) ||
                    (bus.iflush && ((cntQ != '0) || pop)) ||
                    expired) begin
                    stateD = HOLD;
                end
            end
            HOLD: begin
                if (bus.iwd_ready) begin
                    stateD = FILL;
                    laneD  = '0;
                    keepD  = '0;
                    cntD   = '0;
                end
            end
            default: stateD = FILL;
        endcase
    end

    // State, lane and keep registers.
    always_ff @(posedge iclk or posedge ireset) begin
        if (ireset) begin
            stateQ <= FILL;
            laneQ  <= '0;
            keepQ  <= '0;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            laneQ  <= laneD;
            keepQ  <= keepD;
            cntQ   <= cntD;
        end
    end

    assign bus.ofifo_rd  = pop;
    assign bus.owd_valid = (stateQ == HOLD);
    assign bus.owd_data  = laneQ;
    assign bus.owd_keep  = keepQ;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer behind a simple FIFO model.
module tb_fifo_word_packer;

    logic iclk = 1'b0;
    logic ireset;

    always #5 iclk = ~iclk;

    fifo_word_packer_if #(.pBITS(8), .pLANES(4)) bus ();

    fifo_word_packer #(
        .pBITS    (8),
        .pLANES   (4),
        .pTIMEOUT (16)
    ) dut (
        .iclk   (iclk),
        .ireset (ireset),
        .bus    (bus)
    );

    // Upstream FIFO model: head is visible combinationally, popped on ofifo_rd.
    logic [7:0] mem [64];
    int         wrPtr = 0;
    int         rdPtr = 0;

    assign bus.ififo_empty = (wrPtr == rdPtr);
    assign bus.ififo_data  = mem[rdPtr[5:0]];

    always @(posedge iclk) begin
        if (bus.ofifo_rd) rdPtr <= rdPtr + 1;
    end

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic push(input logic [7:0] b);
        mem[wrPtr[5:0]] = b;
        wrPtr = wrPtr + 1;
    endtask

    // Step to the next sample point (1 time unit after a falling edge) until
    // owd_valid is seen or the budget runs out.
    task automatic waitValid(input int maxCyc, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while ((cyc < maxCyc) && !seen) begin
            @(negedge iclk);
            #1;
            cyc++;
            if (bus.owd_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge iclk);
        #1;
        nCompared++;
        if (bus.owd_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_valid: got %b, expected 0", bus.owd_valid);
        end
        nCompared++;
        if (bus.owd_data !== 32'h0) begin
            nMismatched++;
            $display("FAIL reset_data: got %h, expected 00000000", bus.owd_data);
        end
        nCompared++;
        if (bus.owd_keep !== 4'b0000) begin
            nMismatched++;
            $display("FAIL reset_keep: got %b, expected 0000", bus.owd_keep);
        end
        nCompared++;
        if (bus.ofifo_rd !== 1'b0) begin
            nMismatched++;
            $display("FAIL reset_rd: got %b, expected 0", bus.ofifo_rd);
        end
        @(negedge iclk);
        ireset = 1'b0;
        repeat (2) @(negedge iclk);
    endtask

    task automatic test_full_word;
        int cyc;
        bit seen;
        bus.iwd_ready = 1'b1;
        @(negedge iclk);
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        waitValid(10, cyc, seen);
        nCompared++;
        if (!seen || cyc != 4) begin
            nMismatched++;
            $display("FAIL full_latency: got seen=%0d cyc=%0d, expected seen=1 cyc=4", seen, cyc);
        end
        nCompared++;
        if (bus.owd_data !== 32'h44332211) begin
            nMismatched++;
            $display("FAIL full_data: got %h, expected 44332211", bus.owd_data);
        end
        nCompared++;
        if (bus.owd_keep !== 4'b1111) begin
            nMismatched++;
            $display("FAIL full_keep: got %b, expected 1111", bus.owd_keep);
        end
        @(negedge iclk);
        #1;
        nCompared++;
        if (bus.owd_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL full_one_cycle: got valid=%b, expected 0", bus.owd_valid);
        end
    endtask

    task automatic test_backpressure;
        int cyc;
        bit seen;
        int bad;
        bus.iwd_ready = 1'b0;
        @(negedge iclk);
        for (int i = 1; i <= 8; i++) push(8'(i));
        waitValid(10, cyc, seen);
        nCompared++;
        if (!seen || bus.owd_data !== 32'h04030201) begin
            nMismatched++;
            $display("FAIL bp_first: got seen=%0d data=%h, expected 1 04030201", seen, bus.owd_data);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge iclk);
            #1;
            if (bus.owd_valid !== 1'b1 || bus.owd_data !== 32'h04030201 ||
                bus.owd_keep !== 4'b1111 || bus.ofifo_rd !== 1'b0) bad++;
        end
        nCompared++;
        if (bad != 0) begin
            nMismatched++;
            $display("FAIL bp_hold: got %0d unstable cycles, expected 0", bad);
        end
        bus.iwd_ready = 1'b1;
        // Handshake edge pops nothing, then four pops: word every pLANES+1.
        waitValid(12, cyc, seen);
        nCompared++;
        if (!seen || cyc != 5) begin
            nMismatched++;
            $display("FAIL bp_second_latency: got seen=%0d cyc=%0d, expected 1 5", seen, cyc);
        end
        nCompared++;
        if (bus.owd_data !== 32'h08070605) begin
            nMismatched++;
            $display("FAIL bp_second_data: got %h, expected 08070605", bus.owd_data);
        end
        @(negedge iclk);
        #1;
        nCompared++;
        if (bus.owd_valid !== 1'b0 || rdPtr != wrPtr) begin
            nMismatched++;
            $display("FAIL bp_drain: got valid=%b left=%0d, expected 0 0",
                     bus.owd_valid, wrPtr - rdPtr);
        end
    endtask

    task automatic test_flush;
        int seenValid;
        bus.iwd_ready = 1'b1;
        @(negedge iclk);
        push(8'hAA); push(8'hBB);
        repeat (3) @(negedge iclk);
        bus.iflush = 1'b1;
        @(negedge iclk);
        bus.iflush = 1'b0;
        #1;
        nCompared++;
        if (bus.owd_valid !== 1'b1) begin
            nMismatched++;
            $display("FAIL flush_valid: got %b, expected 1", bus.owd_valid);
        end
        nCompared++;
        if (bus.owd_data !== 32'h0000BBAA) begin
            nMismatched++;
            $display("FAIL flush_data: got %h, expected 0000bbaa", bus.owd_data);
        end
        nCompared++;
        if (bus.owd_keep !== 4'b0011) begin
            nMismatched++;
            $display("FAIL flush_keep: got %b, expected 0011", bus.owd_keep);
        end
        @(negedge iclk);
        #1;
        bus.iflush = 1'b1;
        @(negedge iclk);
        bus.iflush = 1'b0;
        seenValid = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.owd_valid !== 1'b0) seenValid++;
            @(negedge iclk);
        end
        nCompared++;
        if (seenValid != 0) begin
            nMismatched++;
            $display("FAIL flush_empty: got %0d valid cycles, expected 0", seenValid);
        end
    endtask

    task automatic test_timeout;
        int cyc;
        bit seen;
        bus.iwd_ready = 1'b1;
        @(negedge iclk);
        push(8'hCC);
        // cyc=1 samples right after the pop edge; rise 16 edges later is cyc=17.
        waitValid(30, cyc, seen);
        nCompared++;
        if (!seen || cyc != 17) begin
            nMismatched++;
            $display("FAIL timeout_latency: got seen=%0d cyc=%0d, expected 1 17", seen, cyc);
        end
        nCompared++;
        if (bus.owd_keep !== 4'b0001 || bus.owd_data !== 32'h000000CC) begin
            nMismatched++;
            $display("FAIL timeout_word: got keep=%b data=%h, expected 0001 000000cc",
                     bus.owd_keep, bus.owd_data);
        end
        @(negedge iclk);
        @(negedge iclk);
        push(8'h5A);
        // After 15 idle edges the counter sits at pTIMEOUT-1.
        repeat (16) @(negedge iclk);
        #1;
        nCompared++;
        if (bus.owd_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL restart_early: got valid=%b, expected 0", bus.owd_valid);
        end
        push(8'h6B);
        waitValid(40, cyc, seen);
        nCompared++;
        if (!seen || cyc != 17) begin
            nMismatched++;
            $display("FAIL restart_latency: got seen=%0d cyc=%0d, expected 1 17", seen, cyc);
        end
        nCompared++;
        if (bus.owd_keep !== 4'b0011 || bus.owd_data !== 32'h00006B5A) begin
            nMismatched++;
            $display("FAIL restart_word: got keep=%b data=%h, expected 0011 00006b5a",
                     bus.owd_keep, bus.owd_data);
        end
        @(negedge iclk);
    endtask

    task automatic test_flush_with_pop;
        bus.iwd_ready = 1'b1;
        @(negedge iclk);
        push(8'h01); push(8'h02);
        @(negedge iclk);
        @(negedge iclk);
        push(8'h03);
        bus.iflush = 1'b1;
        @(negedge iclk);
        bus.iflush = 1'b0;
        #1;
        nCompared++;
        if (bus.owd_valid !== 1'b1 || bus.owd_keep !== 4'b0111) begin
            nMismatched++;
            $display("FAIL flushpop_keep: got valid=%b keep=%b, expected 1 0111",
                     bus.owd_valid, bus.owd_keep);
        end
        nCompared++;
        if (bus.owd_data !== 32'h00030201) begin
            nMismatched++;
            $display("FAIL flushpop_data: got %h, expected 00030201", bus.owd_data);
        end
        @(negedge iclk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit seen;
        int rdBefore;
        bus.iwd_ready = 1'b0;
        @(negedge iclk);
        push(8'h91); push(8'h92); push(8'h93); push(8'h94);
        waitValid(10, cyc, seen);
        @(negedge iclk);
        ireset = 1'b1;
        push(8'hA1); push(8'hA2);
        rdBefore = rdPtr;
        #1;
        nCompared++;
        if (!seen || bus.owd_valid !== 1'b0 || bus.owd_data !== 32'h0 ||
            bus.owd_keep !== 4'b0000) begin
            nMismatched++;
            $display("FAIL rst_hold: got seen=%0d valid=%b data=%h keep=%b, expected 1 0 0 0",
                     seen, bus.owd_valid, bus.owd_data, bus.owd_keep);
        end
        nCompared++;
        if (bus.ofifo_rd !== 1'b0) begin
            nMismatched++;
            $display("FAIL rst_rd: got %b, expected 0", bus.ofifo_rd);
        end
        @(negedge iclk);
        #1;
        nCompared++;
        if (rdPtr != rdBefore) begin
            nMismatched++;
            $display("FAIL rst_nopop: got %0d pops, expected 0", rdPtr - rdBefore);
        end
        bus.iwd_ready = 1'b1;
        ireset = 1'b0;
        repeat (2) @(negedge iclk);
        #1;
        nCompared++;
        if (bus.owd_keep !== 4'b0011 || bus.owd_data !== 32'h0000A2A1) begin
            nMismatched++;
            $display("FAIL rst_partial: got keep=%b data=%h, expected 0011 0000a2a1",
                     bus.owd_keep, bus.owd_data);
        end
        ireset = 1'b1;
        #1;
        nCompared++;
        if (bus.owd_keep !== 4'b0000 || bus.owd_data !== 32'h0 || bus.owd_valid !== 1'b0) begin
            nMismatched++;
            $display("FAIL rst_partial_clear: got keep=%b data=%h valid=%b, expected 0 0 0",
                     bus.owd_keep, bus.owd_data, bus.owd_valid);
        end
        @(negedge iclk);
        ireset = 1'b0;
        push(8'hB1); push(8'hB2); push(8'hB3); push(8'hB4);
        waitValid(10, cyc, seen);
        nCompared++;
        if (!seen || cyc != 4 || bus.owd_data !== 32'hB4B3B2B1 || bus.owd_keep !== 4'b1111) begin
            nMismatched++;
            $display("FAIL rst_clean_word: got seen=%0d cyc=%0d data=%h keep=%b, expected 1 4 b4b3b2b1 1111",
                     seen, cyc, bus.owd_data, bus.owd_keep);
        end
        @(negedge iclk);
    endtask

    initial begin
        ireset        = 1'b1;
        bus.iflush    = 1'b0;
        bus.iwd_ready = 1'b0;
        test_reset;
        test_full_word;
        test_backpressure;
        test_flush;
        test_timeout;
        test_flush_with_pop;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
